// File: rtl/mul_requester.sv
// mul_requester: initiator side of the shift-add multiplier handshake.
// Accepts operand pairs (valid/ready), issues a one-cycle valid_data request,
// waits for done_flag, captures the product into a one-entry result register
// and holds ack until the multiplier drops done_flag.
// Optional build macro: MULREQ_TIMEOUT_EN adds a bounded WAIT with abort pulse.
module mul_requester #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               valid_data,
  input  logic               done_flag,
  input  logic [2*WIDTH-1:0] product,
  output logic               ack,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic [CNT_W-1:0]   done_count,
  output logic               timeout
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_ACK  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             valid_data_q, valid_data_d;
  logic             ack_q, ack_d;
  logic             res_valid_q, res_valid_d;
  logic [PW-1:0]    res_data_q, res_data_d;
  logic [CNT_W-1:0] done_count_q, done_count_d;

  logic accept_c;
  logic capture_c;
  logic consume_c;
  logic tmo_fire_c;

  // Handshake qualifiers shared by next-state and output logic
  assign accept_c  = (state_q == S_IDLE) && in_valid;
  assign capture_c = (state_q == S_WAIT) && done_flag && (!res_valid_q || res_ready);
  assign consume_c = res_valid_q && res_ready;

`ifdef MULREQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_q;
  logic            stall_c;

  // A completed product blocked by a full result register is not a hang
  assign stall_c    = done_flag && res_valid_q && !res_ready;
  assign tmo_fire_c = (state_q == S_WAIT) && !capture_c && !stall_c &&
                      (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // WAIT cycle counter: zero outside WAIT, frozen while stalled
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q != S_WAIT) begin
      wait_cnt_d = '0;
    end else if (!stall_c) begin
      wait_cnt_d = wait_cnt_q + TO_W'(1);
    end
  end

  // Timeout counter and abort pulse registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= tmo_fire_c;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_cfg;

  assign tmo_fire_c = 1'b0;
  assign unused_cfg = |TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
`endif

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (capture_c) begin
          state_d = S_ACK;
        end else if (tmo_fire_c) begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        if (!done_flag) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output next values; strobes are derived from the state being entered
  always_comb begin
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    valid_data_d = (state_d == S_REQ);
    ack_d        = (state_d == S_ACK) || tmo_fire_c;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    done_count_d = done_count_q;

    if (accept_c) begin
      op_a_d = in_a;
      op_b_d = in_b;
    end

    // Capture wins over a same-cycle consume so the new product stays valid
    if (capture_c) begin
      res_valid_d  = 1'b1;
      res_data_d   = product;
      done_count_d = done_count_q + CNT_W'(1);
    end else if (consume_c) begin
      res_valid_d = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      valid_data_q <= 1'b0;
      ack_q        <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      done_count_q <= '0;
    end else begin
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      valid_data_q <= valid_data_d;
      ack_q        <= ack_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      done_count_q <= done_count_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign valid_data = valid_data_q;
  assign ack        = ack_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_mul_requester.sv
// Directed bench for mul_requester with a behavioural multiplier responder.
// A second instance with a 2-bit counter exercises done_count wrap-around.
module tb_mul_requester;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 3;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          done_flag = 1'b0;
  logic [2*W-1:0] product = '0;
  logic          res_ready = 1'b0;

  logic          in_ready, valid_data, ack, res_valid, timeout;
  logic [W-1:0]  op_a, op_b;
  logic [2*W-1:0] res_data;
  logic [15:0]   done_count;

  logic          in_ready2, valid_data2, ack2, res_valid2, timeout2;
  logic [W-1:0]  op_a2, op_b2;
  logic [2*W-1:0] res_data2;
  logic [1:0]    done_count2;

  int n_checks = 0;
  int n_fail   = 0;
  logic stub_mode = 1'b0;

  mul_requester #(.WIDTH(W), .TIMEOUT_CYCLES(64), .CNT_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .op_a(op_a), .op_b(op_b), .valid_data(valid_data),
    .done_flag(done_flag), .product(product), .ack(ack), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .done_count(done_count),
    .timeout(timeout)
  );

  mul_requester #(.WIDTH(W), .TIMEOUT_CYCLES(64), .CNT_W(2)) dut_w2 (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .op_a(op_a2), .op_b(op_b2), .valid_data(valid_data2),
    .done_flag(done_flag), .product(product), .ack(ack2), .res_valid(res_valid2),
    .res_ready(res_ready), .res_data(res_data2), .done_count(done_count2),
    .timeout(timeout2)
  );

  always #5 Clock = ~Clock;

  // Multiplier responder: request -> LAT cycles -> done_flag held until ack
  int             m_st = 0;
  int             m_cnt = 0;
  logic [2*W-1:0] m_prod = '0;
  always @(negedge Clock or posedge Reset) begin
    if (Reset) begin
      m_st = 0; m_cnt = 0; done_flag = 1'b0; product = '0;
    end else begin
      case (m_st)
        0: if (valid_data && !stub_mode) begin
             m_prod = (2*W)'(op_a) * (2*W)'(op_b);
             m_cnt  = LAT;
             m_st   = 1;
           end
        1: if (m_cnt <= 1) begin
             done_flag = 1'b1; product = m_prod; m_st = 2;
           end else begin
             m_cnt = m_cnt - 1;
           end
        default: if (ack) begin
             done_flag = 1'b0; product = '0; m_st = 0;
           end
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic wait_res_valid(input string tag);
    int n = 0;
    while (!res_valid && n < 50) begin tick(); n++; end
    check(tag, 64'(res_valid), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check(tag, 64'(in_ready), 64'd1);
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check(tag, 64'(res_valid), 64'd0);
  endtask

  // Full transaction from an IDLE negedge; leaves the result unread
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp, input logic [15:0] exp_cnt);
    in_a = a; in_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_vd_hi"}, 64'(valid_data), 64'd1);
    tick();
    check({tag, "_vd_lo"}, 64'(valid_data), 64'd0);
    wait_res_valid({tag, "_rv"});
    check({tag, "_data"}, res_data, exp);
    check({tag, "_cnt"}, 64'(done_count), 64'(exp_cnt));
    check({tag, "_ack_hi"}, 64'(ack), 64'd1);
    wait_idle({tag, "_idle"});
    check({tag, "_ack_lo"}, 64'(ack), 64'd0);
  endtask

  initial begin
    int n;
    tick();
    // Reset state
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_op_a", 64'(op_a), 64'd0);
    check("rst_valid_data", 64'(valid_data), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_count", 64'(done_count), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    Reset = 1'b0;
    tick();

    // 3 x 5
    run_op("t1", 32'd3, 32'd5, 64'd15, 16'd1);
    consume("t1_consume");

    // Full-scale operands
    run_op("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 16'd2);
    consume("t2_consume");

    // Back-to-back with result register full
    run_op("t3a", 32'd7, 32'd9, 64'd63, 16'd3);
    in_a = 32'd2; in_b = 32'd4; in_valid = 1'b1;
    tick();
    in_a = 32'd99; in_b = 32'd99;
    n = 0;
    while (!done_flag && n < 20) begin tick(); n++; end
    check("t3_done_seen", 64'(done_flag), 64'd1);
    tick(); tick();
    check("t3_stall_ack", 64'(ack), 64'd0);
    check("t3_stall_busy", 64'(in_ready), 64'd0);
    check("t3_stall_data", res_data, 64'd63);
    check("t3_stall_rv", 64'(res_valid), 64'd1);
    check("t3_stall_cnt", 64'(done_count), 64'd3);
    check("t3_op_a_hold", 64'(op_a), 64'd2);
    in_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t3_swap_data", res_data, 64'd8);
    check("t3_swap_rv", 64'(res_valid), 64'd1);
    check("t3_swap_ack", 64'(ack), 64'd1);
    check("t3_swap_cnt", 64'(done_count), 64'd4);
    wait_idle("t3_idle");

    // Reset during WAIT with an unread result pending
    in_a = 32'd10; in_b = 32'd10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t4_in_wait", 64'(in_ready), 64'd0);
    Reset = 1'b1;
    tick();
    check("t4_in_ready", 64'(in_ready), 64'd1);
    check("t4_op_a", 64'(op_a), 64'd0);
    check("t4_op_b", 64'(op_b), 64'd0);
    check("t4_vd", 64'(valid_data), 64'd0);
    check("t4_ack", 64'(ack), 64'd0);
    check("t4_rv", 64'(res_valid), 64'd0);
    check("t4_data", res_data, 64'd0);
    check("t4_cnt", 64'(done_count), 64'd0);
    check("t4_tmo", 64'(timeout), 64'd0);
    Reset = 1'b0;
    tick();
    run_op("t4b", 32'd6, 32'd7, 64'd42, 16'd1);
    check("t4b_cnt2", 64'(done_count2), 64'd1);
    consume("t4b_consume");

    // Counter wrap on the 2-bit instance
    for (int i = 0; i < 3; i++) begin
      run_op("t6", 32'd1, 32'd1, 64'd1, 16'(2 + i));
      check("t6_cnt_wrap", 64'(done_count2), 64'((2 + i) % 4));
      consume("t6_consume");
    end

`ifdef MULREQ_TIMEOUT_EN
    // Multiplier never answers: abort after 64 WAIT cycles
    begin
      logic [15:0] cnt_before;
      int k;
      cnt_before = done_count;
      stub_mode = 1'b1;
      in_a = 32'd5; in_b = 32'd5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      k = 0;
      while (!timeout && k < 200) begin tick(); k++; end
      check("t5_pulse", 64'(timeout), 64'd1);
      check("t5_cycle", 64'(k), 64'd65);
      check("t5_ack", 64'(ack), 64'd1);
      check("t5_idle", 64'(in_ready), 64'd1);
      check("t5_cnt", 64'(done_count), 64'(cnt_before));
      tick();
      check("t5_one_shot", 64'(timeout), 64'd0);
      check("t5_ack_lo", 64'(ack), 64'd0);
      stub_mode = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
